// File: rtl/data_sec_writer.sv
// Captures data-section words into a local buffer, then drains them to the cache one write at a time.
// Optional running checksum of captured words is enabled by defining DSW_CHECKSUM_EN.
module data_sec_writer #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              rdata_buf,
    input  logic                     rdata_buf_ready,
    input  logic                     cache_buf_ready,
    input  logic                     cache_ready,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_ack,
    output logic                     cache_write_done,
    output logic [$clog2(DEPTH):0]   word_count,
    output logic                     overflow,
    output logic [31:0]              checksum
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_FILL, S_RD, S_REQ, S_DONE} state_t;

    state_t         state_q;
    logic [31:0]    buf_q [DEPTH];
    logic [31:0]    rd_data_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;
    logic [CW-1:0]  idx_q;
    logic           mem_req_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic           done_q;
    logic           overflow_q;
    logic           capture;
    logic           full;
    logic           accept;

    assign full    = (count_q == CW'(DEPTH));
    assign capture = (state_q == S_FILL) && rdata_buf_ready && cache_buf_ready;
    assign accept  = capture && !full;
    assign count_d = count_q + CW'(accept);

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            buf_q[count_q[AW-1:0]] <= rdata_buf;
        end
    end

    // Each word costs a read cycle, a request-setup cycle, then the held request until ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FILL;
            rd_data_q  <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            mem_req_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_FILL: begin
                    count_q <= count_d;
                    if (capture && full) begin
                        overflow_q <= 1'b1;
                    end
                    if (cache_ready) begin
                        idx_q <= '0;
                        if (count_d == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    rd_data_q <= buf_q[idx_q[AW-1:0]];
                    state_q   <= S_REQ;
                end
                S_REQ: begin
                    if (!mem_req_q) begin
                        mem_req_q <= 1'b1;
                        addr_q    <= BASE_ADDR + (32'(idx_q) << 2);
                        wdata_q   <= rd_data_q;
                    end else if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (idx_q == count_q - CW'(1)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + CW'(1);
                            state_q <= S_RD;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_FILL;
                end
            endcase
        end
    end

`ifdef DSW_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else if (accept) begin
            checksum_q <= checksum_q + rdata_buf;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 32'h0;
`endif

    assign mem_req          = mem_req_q;
    assign mem_addr         = addr_q;
    assign mem_wdata        = wdata_q;
    assign cache_write_done = done_q;
    assign word_count       = count_q;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_data_sec_writer.sv
// Bench for data_sec_writer: a capture/drain model checked every cycle plus directed literal checks.
module tb_data_sec_writer;

    localparam int          DEPTH = 4;
    localparam int          CW    = 3;
    localparam logic [31:0] BASE  = 32'hFFFF_FFF8;

    logic           clk;
    logic           rst;
    logic [31:0]    rdata_buf;
    logic           rdata_buf_ready;
    logic           cache_buf_ready;
    logic           cache_ready;
    logic           mem_req;
    logic [31:0]    mem_addr;
    logic [31:0]    mem_wdata;
    logic           mem_ack;
    logic           cache_write_done;
    logic [CW-1:0]  word_count;
    logic           overflow;
    logic [31:0]    checksum;

    data_sec_writer #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .rdata_buf(rdata_buf), .rdata_buf_ready(rdata_buf_ready),
        .cache_buf_ready(cache_buf_ready), .cache_ready(cache_ready), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .cache_write_done(cache_write_done), .word_count(word_count), .overflow(overflow),
        .checksum(checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    int donePulses = 0;
    bit started = 0;
    bit ackTie = 0;
    int ackDelay = 0;
    int stall = 0;

    logic [31:0] wAddr[$];
    logic [31:0] wData[$];
    int          wCyc[$];

    // Model phases: 0 filling, 1 gap before request, 2 request held, 3 finished
    int          mPhase;
    int          mGap;
    int          mIdx;
    int          mCnt;
    bit          mOvf;
    bit          mPulse;
    bit          mEverReq;
    logic [31:0] mSum;
    logic [31:0] mWords[DEPTH];
    logic [31:0] expSum;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic checkWrite(input int i, input logic [31:0] a, input logic [31:0] d);
        if (i < wAddr.size()) begin
            checkOutput($sformatf("write%0d_addr", i), wAddr[i], a);
            checkOutput($sformatf("write%0d_data", i), wData[i], d);
        end else begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL write%0d_missing: got %0d writes expected more than %0d", i, wAddr.size(), i);
        end
    endtask

    always @(posedge clk) begin
        cycle++;
        if (!rst && mem_req && mem_ack) begin
            wAddr.push_back(mem_addr);
            wData.push_back(mem_wdata);
            wCyc.push_back(cycle);
        end
        mPulse = 0;
        if (rst) begin
            mPhase = 0; mGap = 0; mIdx = 0; mCnt = 0;
            mOvf = 0; mEverReq = 0; mSum = 32'h0;
        end else begin
            case (mPhase)
                0: begin
                    if (rdata_buf_ready && cache_buf_ready) begin
                        if (mCnt < DEPTH) begin
                            mWords[mCnt] = rdata_buf;
                            mCnt++;
                            mSum = mSum + rdata_buf;
                        end else begin
                            mOvf = 1;
                        end
                    end
                    if (cache_ready) begin
                        if (mCnt == 0) begin
                            mPhase = 3; mPulse = 1;
                        end else begin
                            mPhase = 1; mGap = 2; mIdx = 0;
                        end
                    end
                end
                1: begin
                    mGap--;
                    if (mGap == 0) begin
                        mPhase = 2; mEverReq = 1;
                    end
                end
                2: begin
                    if (mem_ack) begin
                        if (mIdx == mCnt - 1) begin
                            mPhase = 3; mPulse = 1;
                        end else begin
                            mIdx++; mPhase = 1; mGap = 2;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        if (started) begin
`ifdef DSW_CHECKSUM_EN
            expSum = mSum;
`else
            expSum = 32'h0;
`endif
            checkOutput("mem_req", 32'(mem_req), 32'(mPhase == 2));
            checkOutput("cache_write_done", 32'(cache_write_done), 32'(mPulse));
            checkOutput("word_count", 32'(word_count), 32'(mCnt));
            checkOutput("overflow", 32'(overflow), 32'(mOvf));
            checkOutput("checksum", checksum, expSum);
            if (mPhase == 2) begin
                checkOutput("mem_addr", mem_addr, BASE + 32'(mIdx * 4));
                checkOutput("mem_wdata", mem_wdata, mWords[mIdx]);
            end else if (!mEverReq) begin
                checkOutput("mem_addr_idle", mem_addr, 32'h0);
                checkOutput("mem_wdata_idle", mem_wdata, 32'h0);
            end
            if (cache_write_done) donePulses++;
        end
    end

    // Cache responder: acks after ackDelay held-request cycles, or holds ack high when tied
    always @(negedge clk) begin
        if (ackTie) begin
            mem_ack = 1'b1;
        end else if (mem_req) begin
            if (stall >= ackDelay) begin
                mem_ack = 1'b1; stall = 0;
            end else begin
                mem_ack = 1'b0; stall++;
            end
        end else begin
            mem_ack = 1'b0; stall = 0;
        end
    end

    task automatic applyStimulus(input logic [31:0] w, input bit cbr, input bit cr);
        @(negedge clk);
        rdata_buf = w; rdata_buf_ready = 1'b1; cache_buf_ready = cbr; cache_ready = cr;
        @(negedge clk);
        rdata_buf_ready = 1'b0; cache_buf_ready = 1'b0; cache_ready = 1'b0;
    endtask

    task automatic pulseCacheReady();
        @(negedge clk);
        cache_ready = 1'b1;
        @(negedge clk);
        cache_ready = 1'b0;
    endtask

    task automatic doReset(input bit withInputs);
        @(negedge clk);
        rst = 1'b1;
        ackTie = 0;
        if (withInputs) begin
            rdata_buf = 32'hBAD0BAD0; rdata_buf_ready = 1'b1;
            cache_buf_ready = 1'b1; cache_ready = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        rdata_buf_ready = 1'b0; cache_buf_ready = 1'b0; cache_ready = 1'b0;
        wAddr.delete(); wData.delete(); wCyc.delete();
        donePulses = 0;
    endtask

    task automatic waitDone(input int budget);
        for (int n = 0; n < budget && donePulses == 0; n++) @(negedge clk);
        checkOutput("drain_done_seen", 32'(donePulses), 32'd1);
    endtask

    initial begin
        int startCyc;
        int reqCyc;
        logic [31:0] expC4;
        rst = 1'b1; rdata_buf = 32'h0; rdata_buf_ready = 1'b0;
        cache_buf_ready = 1'b0; cache_ready = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        started = 1;
        checkOutput("rst_mem_req", 32'(mem_req), 32'h0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_word_count", 32'(word_count), 32'h0);
        checkOutput("rst_overflow", 32'(overflow), 32'h0);
        rst = 1'b0;

        // Three captures, ack tied high, latency and throughput pinned by literals
        ackTie = 1;
        applyStimulus(32'h11111111, 1, 0);
        applyStimulus(32'h22222222, 1, 0);
        applyStimulus(32'h33333333, 1, 0);
        @(negedge clk);
        cache_ready = 1'b1;
        @(posedge clk); #1;
        startCyc = cycle;
        @(negedge clk);
        cache_ready = 1'b0;
        reqCyc = startCyc + 100;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (mem_req) begin
                reqCyc = cycle;
                break;
            end
        end
        checkOutput("req_latency", 32'(reqCyc - startCyc), 32'd2);
        waitDone(40);
        applyStimulus(32'h44444444, 1, 1);
        repeat (10) @(negedge clk);
        checkOutput("a_write_count", 32'(wAddr.size()), 32'd3);
        checkWrite(0, 32'hFFFFFFF8, 32'h11111111);
        checkWrite(1, 32'hFFFFFFFC, 32'h22222222);
        checkWrite(2, 32'h00000000, 32'h33333333);
        if (wCyc.size() >= 2) checkOutput("a_throughput", 32'(wCyc[1] - wCyc[0]), 32'd3);
        checkOutput("a_done_pulses", 32'(donePulses), 32'd1);
        checkOutput("a_word_count", 32'(word_count), 32'd3);

        // Drain with nothing captured
        doReset(0);
        pulseCacheReady();
        repeat (6) @(negedge clk);
        checkOutput("b_done_pulses", 32'(donePulses), 32'd1);
        checkOutput("b_write_count", 32'(wAddr.size()), 32'd0);

        // Overflow: fifth word dropped
        doReset(0);
        applyStimulus(32'h01000001, 1, 0);
        applyStimulus(32'h02000002, 1, 0);
        applyStimulus(32'h03000003, 1, 0);
        applyStimulus(32'h04000004, 1, 0);
        applyStimulus(32'h05000005, 1, 0);
`ifdef DSW_CHECKSUM_EN
        expC4 = 32'h0A00000A;
`else
        expC4 = 32'h0;
`endif
        checkOutput("c_word_count", 32'(word_count), 32'd4);
        checkOutput("c_overflow", 32'(overflow), 32'd1);
        checkOutput("c_checksum", checksum, expC4);
        pulseCacheReady();
        waitDone(60);
        repeat (4) @(negedge clk);
        checkOutput("c_write_count", 32'(wAddr.size()), 32'd4);
        checkWrite(2, 32'h00000000, 32'h03000003);
        checkWrite(3, 32'h00000004, 32'h04000004);

        // Stalled acks; reset also asserted alongside a capture and cache_ready
        doReset(1);
        checkOutput("d_rst_priority_count", 32'(word_count), 32'd0);
        ackDelay = 5;
        applyStimulus(32'hAAAA0001, 1, 0);
        applyStimulus(32'hAAAA0002, 1, 0);
        applyStimulus(32'hAAAA0003, 1, 0);
        pulseCacheReady();
        waitDone(100);
        checkOutput("d_write_count", 32'(wAddr.size()), 32'd3);
        checkWrite(0, 32'hFFFFFFF8, 32'hAAAA0001);
        checkWrite(1, 32'hFFFFFFFC, 32'hAAAA0002);
        checkWrite(2, 32'h00000000, 32'hAAAA0003);
        if (wCyc.size() >= 2) checkOutput("d_stall_period", 32'(wCyc[1] - wCyc[0]), 32'd8);

        // Reset while word 1 is being requested, then refill and drain one word
        doReset(0);
        ackDelay = 0;
        applyStimulus(32'h10101010, 1, 0);
        applyStimulus(32'h20202020, 1, 0);
        pulseCacheReady();
        for (int n = 0; n < 30 && wAddr.size() == 0; n++) @(negedge clk);
        ackDelay = 100;
        for (int n = 0; n < 30 && !mem_req; n++) @(negedge clk);
        checkOutput("e_word1_req", 32'(mem_req), 32'd1);
        checkOutput("e_word1_addr", mem_addr, 32'hFFFFFFFC);
        repeat (2) @(negedge clk);
        doReset(0);
        checkOutput("e_req_after_rst", 32'(mem_req), 32'd0);
        checkOutput("e_count_after_rst", 32'(word_count), 32'd0);
        ackDelay = 0;
        applyStimulus(32'h5A5A5A5A, 1, 0);
        pulseCacheReady();
        waitDone(40);
        checkOutput("e_write_count", 32'(wAddr.size()), 32'd1);
        checkWrite(0, BASE, 32'h5A5A5A5A);

        // Ignored strobe without capture window; last capture coincident with cache_ready
        doReset(0);
        applyStimulus(32'hA0A0A0A0, 1, 0);
        applyStimulus(32'hDEADBEEF, 0, 0);
        applyStimulus(32'hC0C0C0C0, 1, 1);
        waitDone(40);
        checkOutput("f_write_count", 32'(wAddr.size()), 32'd2);
        checkWrite(0, 32'hFFFFFFF8, 32'hA0A0A0A0);
        checkWrite(1, 32'hFFFFFFFC, 32'hC0C0C0C0);
        checkOutput("f_word_count", 32'(word_count), 32'd2);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
